// File: rtl/score_keeper.sv
// Frame-driven four-digit BCD score counter with a milestone pulse every hundred points.
// Optional high-score tracking is built only when SCORE_KEEPER_HISCORE_EN is defined.
module score_keeper #(
  parameter int unsigned TICKS_PER_POINT = 6
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        frame_tick,
  input  logic        halt,
  input  logic        game_over,
  input  logic        game_rst,
  input  logic [1:0]  digit_sel,
  input  logic        hi_sel,
  output logic [3:0]  digit_out,
  output logic [15:0] score,
  output logic [15:0] hi_score,
  output logic        milestone,
  output logic        new_record
);

  localparam logic [5:0]  LAST_TICK = 6'(TICKS_PER_POINT - 1);
  localparam logic [15:0] SCORE_MAX = 16'h9999;

  // Decimal increment across four packed BCD digits with ripple carry.
  function automatic logic [15:0] bcd_inc(input logic [15:0] value);
    logic [15:0] result;
    logic        carry;
    result = value;
    carry  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (value[4*i +: 4] >= 4'd9) begin
          result[4*i +: 4] = 4'd0;
          carry            = 1'b1;
        end else begin
          result[4*i +: 4] = value[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end else begin
        result[4*i +: 4] = value[4*i +: 4];
      end
    end
    return result;
  endfunction

  function automatic logic [3:0] bcd_nibble(input logic [15:0] value, input logic [1:0] sel);
    logic [3:0] nib;
    case (sel)
      2'd0:    nib = value[3:0];
      2'd1:    nib = value[7:4];
      2'd2:    nib = value[11:8];
      2'd3:    nib = value[15:12];
      default: nib = 4'd0;
    endcase
    return nib;
  endfunction

  logic [5:0]  prescale_r;
  logic [5:0]  prescale_nxt_s;
  logic [15:0] score_r;
  logic [15:0] score_nxt_s;
  logic [15:0] score_inc_s;
  logic        milestone_r;
  logic        milestone_nxt_s;
  logic        running_s;
  logic        point_s;
  logic [15:0] digit_src_s;

  // Prescaler and score next-state; game_rst overrides any coincident tick.
  always_comb begin
    running_s       = !halt && !game_over && !game_rst;
    point_s         = running_s && frame_tick && (prescale_r == LAST_TICK);
    score_inc_s     = bcd_inc(score_r);
    prescale_nxt_s  = prescale_r;
    score_nxt_s     = score_r;
    milestone_nxt_s = 1'b0;
    if (game_rst) begin
      prescale_nxt_s = 6'd0;
      score_nxt_s    = 16'h0000;
    end else if (running_s && frame_tick) begin
      if (point_s) begin
        prescale_nxt_s = 6'd0;
        // Saturated score holds, and so no milestone can fire from 9999.
        if (score_r != SCORE_MAX) begin
          score_nxt_s     = score_inc_s;
          milestone_nxt_s = (score_inc_s[7:0] == 8'h00);
        end else begin
          score_nxt_s     = score_r;
        end
      end else begin
        prescale_nxt_s = prescale_r + 6'd1;
      end
    end else begin
      prescale_nxt_s = prescale_r;
    end
  end

  // Score, prescaler and milestone state.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      prescale_r  <= 6'd0;
      score_r     <= 16'h0000;
      milestone_r <= 1'b0;
    end else begin
      prescale_r  <= prescale_nxt_s;
      score_r     <= score_nxt_s;
      milestone_r <= milestone_nxt_s;
    end
  end

  assign score     = score_r;
  assign milestone = milestone_r;

`ifdef SCORE_KEEPER_HISCORE_EN
  logic        game_over_q_r;
  logic [15:0] hi_score_r;
  logic [15:0] hi_score_nxt_s;
  logic        new_record_r;
  logic        new_record_nxt_s;
  logic        over_rise_s;

  // Packed BCD orders the same as binary, so a plain unsigned compare suffices.
  always_comb begin
    over_rise_s      = game_over && !game_over_q_r && !game_rst;
    hi_score_nxt_s   = hi_score_r;
    new_record_nxt_s = new_record_r;
    if (game_rst) begin
      new_record_nxt_s = 1'b0;
    end else if (over_rise_s && (score_r > hi_score_r)) begin
      hi_score_nxt_s   = score_r;
      new_record_nxt_s = 1'b1;
    end else begin
      hi_score_nxt_s   = hi_score_r;
      new_record_nxt_s = new_record_r;
    end
  end

  // High-score state and game_over edge history.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      game_over_q_r <= 1'b0;
      hi_score_r    <= 16'h0000;
      new_record_r  <= 1'b0;
    end else begin
      game_over_q_r <= game_over;
      hi_score_r    <= hi_score_nxt_s;
      new_record_r  <= new_record_nxt_s;
    end
  end

  assign hi_score    = hi_score_r;
  assign new_record  = new_record_r;
  assign digit_src_s = hi_sel ? hi_score_r : score_r;
`else
  logic unused_hi_sel;

  assign unused_hi_sel = hi_sel;
  assign hi_score      = 16'h0000;
  assign new_record    = 1'b0;
  assign digit_src_s   = score_r;
`endif

  assign digit_out = bcd_nibble(digit_src_s, digit_sel);

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter TICKS_PER_POINT, default 6, number of frame_tick pulses per score point (legal 1..63).
REQ-002 clk  input  1  system clock (VGA pixel clock).
REQ-003 sys_rst  input  1  asynchronous, active-high reset.
REQ-004 frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-005 halt  input  1  level; freezes scoring while high.
REQ-006 game_over  input  1  level from game controller; high while the game is over.
REQ-007 game_rst  input  1  one-cycle synchronous restart pulse.
REQ-008 digit_sel  input  2  digit index for the renderer (0 = units, 3 = thousands).
REQ-009 hi_sel  input  1  renderer select (0 = current score, 1 = high score).
REQ-010 digit_out  output  4  BCD digit chosen by digit_sel and hi_sel; combinational.
REQ-011 score  output  16  current score, four packed BCD digits.
REQ-012 hi_score  output  16  high score, four packed BCD digits.
REQ-013 milestone  output  1  one-cycle pulse on each crossing of a multiple of 100.
REQ-014 new_record  output  1  level; high after the last game beat the high score.

Function
REQ-015 Running condition = !halt && !game_over && !game_rst.
REQ-016 A 6-bit prescaler advances on each frame_tick while running, and holds otherwise.
REQ-017 frame_tick with prescaler == TICKS_PER_POINT-1 -> prescaler wraps to 0 and score increments by 1 on the next clock edge.
REQ-018 Score increment is decimal BCD with ripple carry; no digit ever holds a value above 9.
REQ-019 Score saturates at 9999; later increment events leave score unchanged, the prescaler still wraps, and milestone stays low.
REQ-020 milestone pulses high for exactly one cycle, registered in the same cycle as the score update, when an increment gives lower two digits == 00.
REQ-021 game_rst clears score and prescaler to 0 and clears new_record; hi_score is retained; game_rst wins over a coincident frame_tick.
REQ-022 A registered copy of game_over detects its rising edge.
REQ-023 On the game_over rising edge, if score > hi_score (unsigned, compared as BCD): hi_score <= score and new_record <= 1, both one cycle after the edge.
REQ-024 On the rising edge with score <= hi_score: no change to hi_score or new_record.
REQ-025 A game_over rising edge coincident with game_rst is ignored.
REQ-026 hi_score and new_record change only via REQ-021, REQ-023 and reset.
REQ-027 digit_out = nibble digit_sel of (hi_sel ? hi_score : score); no added latency.

Reset
REQ-028 sys_rst asserted -> immediately: score=0, hi_score=0, prescaler=0, milestone=0, new_record=0, game_over history=0.
REQ-029 Reset mid-operation discards all state, including hi_score; the first increment after release needs a full TICKS_PER_POINT ticks.

Configuration
REQ-030 Macro SCORE_KEEPER_HISCORE_EN defined -> high-score register, compare logic and new_record behave per REQ-022..REQ-026.
REQ-031 Macro undefined -> no high-score register or comparator; hi_score ties to 0, new_record ties to 0, and hi_sel is ignored (digit_out always reads score).

Verification
REQ-032 TICKS_PER_POINT=6, running, 12 frame_ticks -> score=0x0002, milestone never high.
REQ-033 Score preset to 0x0099, 6 ticks -> score=0x0100, milestone high for exactly 1 cycle; same from 0x0999 -> 0x1000 with 1 pulse.
REQ-034 Score at 0x9999, 6 more ticks -> score stays 0x9999, prescaler back at 0, no milestone.
REQ-035 halt=1 for 20 ticks, then game_over=1 for 20 ticks -> score and prescaler unchanged throughout.
REQ-036 (HISCORE_EN) score 0x0042 then game_over rises -> hi_score=0x0042, new_record=1; game_rst -> score=0, new_record=0, hi_score=0x0042; next game ends at 0x0030 -> hi_score unchanged, new_record=0.
REQ-037 sys_rst pulsed mid-run with score 0x0123, hi_score 0x0500 -> all outputs 0 asynchronously; digit_sel=1, hi_sel=1 -> digit_out=0.
